// File: rtl/shift_select_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : shift_select_pipe
//  Description : LANES independent shift/select lanes pushed through a
//                DEPTH-stage elastic valid/ready pipeline. Stage 0 registers
//                the shift/mix results, stage 1 the select/mask results, and
//                any further stages are pure delay. Completed output beats
//                are counted on beat_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_select_pipe #(
    parameter int         WIDTH = 4,
    parameter int         LANES = 2,
    parameter int         DEPTH = 2,
    parameter logic [7:0] FILL  = 8'hA0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*WIDTH-1:0]       sel,
    input  logic [LANES*WIDTH-1:0]       a,
    input  logic [LANES*3-1:0]           shamt_en,
    input  logic [LANES*WIDTH-1:0]       b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*(3*WIDTH+2)-1:0] y,
    output logic [15:0]                  beat_cnt
);

    // Width of one lane's output word {nz, mix, r6, r5, 1'b0}
    localparam int               c_lw   = 3*WIDTH + 2;
    // Fallback constant reduced to lane width
    localparam logic [WIDTH-1:0] c_fill = WIDTH'(FILL);

    // Per-stage valid flags and the ready chain (w_rdy[DEPTH] is the consumer)
    logic [DEPTH-1:0]       r_v;
    logic [DEPTH:0]         w_rdy;

    // Stage 0 payload: results plus the operands stage 1 still needs
    logic [LANES*WIDTH-1:0] r_s0_mix;
    logic [LANES*WIDTH-1:0] r_s0_r5;
    logic [LANES*WIDTH-1:0] r_s0_b;
    logic [LANES*3-1:0]     r_s0_se;

    // Stage 0 combinational results from the input ports
    logic [LANES*WIDTH-1:0] w_mix;
    logic [LANES*WIDTH-1:0] w_r5;

    // Stage 1 combinational packed word built from stage 0 registers
    logic [LANES*c_lw-1:0]  w_word;

    // Stages 1..DEPTH-1 carry the fully packed lane words
    logic [LANES*c_lw-1:0]  r_word [1:DEPTH-1];

    logic [15:0]            r_cnt;

    // Per-lane datapath; lanes never interact
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [2:0]       w_se;
        logic [WIDTH-1:0] w_sh;
        logic [WIDTH-1:0] w_s0_mix;
        logic [WIDTH-1:0] w_s0_r5;
        logic [WIDTH-1:0] w_s0_b;
        logic [2:0]       w_s0_se;
        logic [WIDTH-1:0] w_mask;
        logic [WIDTH-1:0] w_r6;
        logic             w_nz;

        assign w_a  = a[i*WIDTH +: WIDTH];
        assign w_b  = b[i*WIDTH +: WIDTH];
        assign w_se = shamt_en[i*3 +: 3];

        // Stage 0: select operand, and shift a logically by b or the fill value
        assign w_mix[i*WIDTH +: WIDTH] = (|sel[i*WIDTH +: WIDTH]) ? w_a : w_b;
        assign w_sh                    = (|w_se) ? w_b : c_fill;
        assign w_r5[i*WIDTH +: WIDTH]  = w_a >> w_sh;

        assign w_s0_mix = r_s0_mix[i*WIDTH +: WIDTH];
        assign w_s0_r5  = r_s0_r5[i*WIDTH +: WIDTH];
        assign w_s0_b   = r_s0_b[i*WIDTH +: WIDTH];
        assign w_s0_se  = r_s0_se[i*3 +: 3];

        // Stage 1: shamt_en acts as a sign-extended mask on r5 when b is nonzero
        assign w_mask = WIDTH'($signed(w_s0_se));
        assign w_r6   = (|w_s0_b)   ? (w_mask & w_s0_r5) :
                        (|w_s0_mix) ? w_s0_mix           : c_fill;
        assign w_nz   = ~|w_s0_r5;

        assign w_word[i*c_lw +: c_lw] = {w_nz, w_s0_mix, w_r6, w_s0_r5, 1'b0};
    end

    // Ready ripples back from the consumer; an empty stage is always ready
    always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_rdy[k] = ~r_v[k] | w_rdy[k+1];
        end
    end

    // Pipeline registers: each stage loads from its predecessor when ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v      <= '0;
            r_s0_mix <= '0;
            r_s0_r5  <= '0;
            r_s0_b   <= '0;
            r_s0_se  <= '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_word[k] <= '0;
            end
        end else begin
            if (w_rdy[0]) begin
                r_v[0] <= in_valid;
                if (in_valid) begin
                    r_s0_mix <= w_mix;
                    r_s0_r5  <= w_r5;
                    r_s0_b   <= b;
                    r_s0_se  <= shamt_en;
                end
            end
            if (w_rdy[1]) begin
                r_v[1] <= r_v[0];
                if (r_v[0]) begin
                    r_word[1] <= w_word;
                end
            end
            for (int k = 2; k < DEPTH; k++) begin
                if (w_rdy[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_word[k] <= r_word[k-1];
                    end
                end
            end
        end
    end

    // Completed-beat counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_v[DEPTH-1] && out_ready) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign in_ready  = w_rdy[0] & ~rst;
    assign out_valid = r_v[DEPTH-1];
    assign y         = r_word[DEPTH-1];
    assign beat_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_shift_select_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_select_pipe
//  Description : Self-checking bench for shift_select_pipe. Instance u_a is
//                W=4/L=1/D=2/FILL=A0, instance u_b is W=4/L=3/D=4/FILL=A5.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_select_pipe;

    logic clk = 1'b0;
    logic rst;

    // Instance A signals (1 lane, depth 2)
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0]  a_sel, a_a, a_b;
    logic [2:0]  a_se;
    logic [13:0] a_y;
    logic [15:0] a_cnt;

    // Instance B signals (3 lanes, depth 4)
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [11:0] b_sel, b_a, b_b;
    logic [8:0]  b_se;
    logic [41:0] b_y;
    logic [15:0] b_cnt;

    shift_select_pipe #(.WIDTH(4), .LANES(1), .DEPTH(2), .FILL(8'hA0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sel(a_sel), .a(a_a), .shamt_en(a_se), .b(a_b),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .y(a_y), .beat_cnt(a_cnt)
    );

    shift_select_pipe #(.WIDTH(4), .LANES(3), .DEPTH(4), .FILL(8'hA5)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel), .a(b_a), .shamt_en(b_se), .b(b_b),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .y(b_y), .beat_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  sel;
        logic [3:0]  a;
        logic [2:0]  se;
        logic [3:0]  b;
        logic [13:0] y;
    } vec_t;

    vec_t        tbl [9];
    logic [13:0] qa [$];
    logic [41:0] qb [$];
    int          checks = 0;
    int          errors = 0;
    int          na_emit = 0;
    logic [15:0] mcnt_a, mcnt_b;
    logic        acc_a, acc_b, s_ready_a;
    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [13:0] held_a;
    logic [41:0] held_b;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent reference for one 4-bit lane
    function automatic logic [13:0] model(input logic [3:0] s, input logic [3:0] aa,
                                          input logic [3:0] bb, input logic [2:0] se,
                                          input logic [7:0] fill);
        logic [3:0] f, mix, sh, r5, r6, mask;
        logic       nz;
        f    = fill[3:0];
        mix  = (s != 4'h0) ? aa : bb;
        sh   = (se != 3'h0) ? bb : f;
        r5   = (sh > 4'd3) ? 4'h0 : (aa >> sh);
        mask = {se[2], se};
        if (bb != 4'h0)       r6 = mask & r5;
        else if (mix != 4'h0) r6 = mix;
        else                  r6 = f;
        nz   = (r5 == 4'h0);
        return {nz, mix, r6, r5, 1'b0};
    endfunction

    // Negedge monitor: scoreboard push on accept, pop/compare on emit, hold checks
    task automatic mon();
        logic [41:0] eb;
        acc_a     = 1'b0;
        acc_b     = 1'b0;
        s_ready_a = a_in_ready;
        if (rst) begin
            chk("rst_in_ready_a", a_in_ready, 0);
            chk("rst_in_ready_b", b_in_ready, 0);
            qa.delete();
            qb.delete();
            mcnt_a  = 16'h0;
            mcnt_b  = 16'h0;
            stall_a = 1'b0;
            stall_b = 1'b0;
        end else begin
            if (stall_a) begin
                chk("a_hold_valid", a_out_valid, 1);
                chk("a_hold_y", a_y, held_a);
            end
            if (stall_b) begin
                chk("b_hold_valid", b_out_valid, 1);
                chk("b_hold_y", b_y, held_b);
            end
            stall_a = a_out_valid && !a_out_ready;
            held_a  = a_y;
            stall_b = b_out_valid && !b_out_ready;
            held_b  = b_y;
            if (a_out_valid && a_out_ready) begin
                mcnt_a++;
                na_emit++;
                if (qa.size() == 0) chk("a_unexpected_beat", a_out_valid, 0);
                else                chk("a_beat", a_y, qa.pop_front());
            end
            if (b_out_valid && b_out_ready) begin
                mcnt_b++;
                if (qb.size() == 0) chk("b_unexpected_beat", b_out_valid, 0);
                else                chk("b_beat", b_y, qb.pop_front());
            end
            if (a_in_valid && a_in_ready) begin
                qa.push_back(model(a_sel, a_a, a_b, a_se, 8'hA0));
                acc_a = 1'b1;
            end
            if (b_in_valid && b_in_ready) begin
                for (int l = 0; l < 3; l++) begin
                    eb[l*14 +: 14] = model(b_sel[l*4 +: 4], b_a[l*4 +: 4], b_b[l*4 +: 4],
                                           b_se[l*3 +: 3], 8'hA5);
                end
                qb.push_back(eb);
                acc_b = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int e0;

        // Hand-derived vectors for FILL low nibble = 0
        tbl[0] = {4'h1, 4'h8, 3'b001, 4'h1, 14'h1008};
        tbl[1] = {4'h1, 4'h8, 3'b000, 4'h1, 14'h1010};
        tbl[2] = {4'h0, 4'h8, 3'b000, 4'h0, 14'h0010};
        tbl[3] = {4'h0, 4'h0, 3'b000, 4'h0, 14'h2000};
        tbl[4] = {4'h2, 4'hF, 3'b100, 4'h2, 14'h1E06};
        tbl[5] = {4'h0, 4'hF, 3'b111, 4'h4, 14'h2800};
        tbl[6] = {4'h0, 4'h6, 3'b011, 4'h1, 14'h0266};
        tbl[7] = {4'h0, 4'hC, 3'b110, 4'h0, 14'h0018};
        tbl[8] = {4'h8, 4'h5, 3'b010, 4'h0, 14'h0AAA};

        rst = 1'b1;
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        b_in_valid = 1'b1; b_out_ready = 1'b1;
        {a_sel, a_a, a_se, a_b} = 15'h7FFF;
        {b_sel, b_a, b_se, b_b} = '1;
        mcnt_a = 16'h0; mcnt_b = 16'h0;

        // T1: reset with in_valid held high
        @(posedge clk); #1;
        chk("t1_out_valid_a", a_out_valid, 0);
        chk("t1_y_a", a_y, 0);
        chk("t1_cnt_a", a_cnt, 0);
        chk("t1_in_ready_a", a_in_ready, 0);
        chk("t1_out_valid_b", b_out_valid, 0);
        chk("t1_y_b", b_y, 0);
        chk("t1_cnt_b", b_cnt, 0);
        cyc();
        rst = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        cyc();

        // T2: table of single beats, latency exactly 2 cycles
        for (int i = 0; i < 9; i++) begin
            {a_sel, a_a, a_se, a_b} = {tbl[i].sel, tbl[i].a, tbl[i].se, tbl[i].b};
            a_in_valid = 1'b1;
            cyc();
            a_in_valid = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                chk($sformatf("tbl%0d_valid_c%0d", i, k), a_out_valid, (k == 2));
                if (k == 2) chk($sformatf("tbl%0d_y", i), a_y, tbl[i].y);
                cyc();
            end
        end

        // T4: five back-to-back beats, consumer stalls for cycles 3..8
        sent = 0;
        e0   = na_emit;
        for (int c = 0; c < 16; c++) begin
            if (c == 0 || acc_a) {a_sel, a_a, a_se, a_b} = 15'($urandom);
            a_in_valid  = (sent < 5);
            a_out_ready = !(c >= 3 && c <= 8);
            cyc();
            if (c == 5) chk("t4_in_ready_full", s_ready_a, 0);
            if (acc_a) sent++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        cyc();
        chk("t4_emitted", na_emit - e0, 5);
        chk("t4_queue_empty", qa.size(), 0);
        chk("t4_cnt", a_cnt, mcnt_a);

        // T5: reset with two beats in flight
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        {a_sel, a_a, a_se, a_b} = {4'h1, 4'h8, 3'b001, 4'h1};
        cyc();
        {a_sel, a_a, a_se, a_b} = {4'h0, 4'h6, 3'b011, 4'h1};
        cyc();
        a_in_valid = 1'b0;
        cyc();
        chk("t5_full_before_rst", a_out_valid, 1);
        rst = 1'b1;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        cyc();
        rst = 1'b0;
        a_in_valid = 1'b0;
        chk("t5_out_valid", a_out_valid, 0);
        chk("t5_y", a_y, 0);
        chk("t5_cnt", a_cnt, 0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t5_no_stale_%0d", k), a_out_valid, 0);
            cyc();
        end

        // T3: fill path on the FILL=A5, 3-lane, depth-4 instance
        b_out_ready = 1'b1;
        b_sel = 12'h000; b_se = 9'h000; b_b = 12'h000; b_a = {4'h3, 4'h8, 4'h0};
        b_in_valid = 1'b1;
        cyc();
        b_in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("t3_valid_c%0d", k), b_out_valid, (k == 4));
            if (k == 4) chk("t3_fill_y", b_y, {3{14'h20A0}});
            cyc();
        end

        // T6b: random stream with random stalls on the 3-lane instance
        acc_b = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!b_in_valid || acc_b) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                {b_sel, b_a, b_se, b_b} = 45'({$urandom, $urandom});
            end
            b_out_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int k = 0; k < 10; k++) cyc();
        chk("b_drain_empty", qb.size(), 0);
        chk("b_cnt", b_cnt, mcnt_b);

        // T6: beat counter wrap on instance A
        sent = 0;
        a_out_ready = 1'b1;
        for (int c = 0; c < 70000 && sent < 65535; c++) begin
            a_in_valid = 1'b1;
            {a_sel, a_a, a_se, a_b} = 15'($urandom);
            cyc();
            if (acc_a) sent++;
        end
        a_in_valid = 1'b0;
        chk("t6_fed", sent, 65535);
        for (int k = 0; k < 4; k++) cyc();
        chk("t6_cnt_ffff", a_cnt, 16'hFFFF);
        a_in_valid = 1'b1;
        cyc();
        a_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        chk("t6_cnt_wrap", a_cnt, 16'h0000);
        chk("t6_queue_empty", qa.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
